// File: rtl/zorro2_pkg.sv
// Shared Zorro II definitions: bus-cycle state encoding, autoconfig word addresses
// and the idle (negated) level of the 68000-style strobes.
package zorro2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_WAIT,
    ST_LATCH,
    ST_NEG,
    ST_HOLD
  } bus_state_t;

  localparam logic STROBE_IDLE = 1'b1;

  // Autoconfig space at byte 0xE80000; register offsets are word offsets from it
  localparam logic [22:0] AC_BASE_W    = 23'h74_0000;
  localparam logic [7:0]  AC_CONFIG_W  = 8'h24;
  localparam logic [7:0]  AC_SHUTUP_W  = 8'h26;

  function automatic logic [22:0] ac_addr(input logic [7:0] word_ofs);
    return AC_BASE_W + {15'd0, word_ofs};
  endfunction

endpackage

// File: rtl/zorro2_sync.sv
// Flop-chain synchroniser for an active-low asynchronous bus response; resets to
// the negated level so a reset never looks like a slave response.
module zorro2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) chain <= '1;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/zorro2_bus_master.sv
// Zorro II bus-cycle initiator: turns one local request into one 68000-style read
// or write cycle. Define WATCHDOG_EN to bound wait states with a TIMEOUT bus error.
module zorro2_bus_master
  import zorro2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_rwn,
  input  logic [22:0] req_addr,
  input  logic        req_uds_n,
  input  logic        req_lds_n,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic        timeout,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [22:0] ADDR,
  output logic [15:0] DBUS_OUT,
  output logic        DBUS_OE,
  input  logic [15:0] DBUS_IN,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  input  logic        DTACKn,
  input  logic        BERRn
);

  bus_state_t state, state_next;
  logic dtack_s, berr_s;
  logic uds_q, lds_q, err_q;
  logic accept, illegal, as_on, ds_on, oe_on, strobes_off, capture, set_err, finish;

  zorro2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dtack_sync (
    .CLK(CLK), .RESET(RESET), .d(DTACKn), .q(dtack_s)
  );

  zorro2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_berr_sync (
    .CLK(CLK), .RESET(RESET), .d(BERRn), .q(berr_s)
  );

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic wd_clr, wd_inc, wd_fire, to_q;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    illegal     = 1'b0;
    as_on       = 1'b0;
    ds_on       = 1'b0;
    oe_on       = 1'b0;
    strobes_off = 1'b0;
    capture     = 1'b0;
    set_err     = 1'b0;
    finish      = 1'b0;
`ifdef WATCHDOG_EN
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    wd_fire = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (req_uds_n && req_lds_n) begin
            illegal = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ST_T1;
          end
        end
      end
      ST_T1: begin
        as_on      = 1'b1;
        ds_on      = RWn;
        oe_on      = !RWn;
        state_next = ST_T2;
      end
      ST_T2: begin
        // Writes hold the data strobes back one clock so data is stable first
        ds_on      = !RWn;
        state_next = ST_WAIT;
`ifdef WATCHDOG_EN
        wd_clr = 1'b1;
`endif
      end
      ST_WAIT: begin
        if (!berr_s) begin
          set_err    = 1'b1;
          state_next = ST_NEG;
        end else if (!dtack_s) begin
          state_next = ST_LATCH;
`ifdef WATCHDOG_EN
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          set_err    = 1'b1;
          wd_fire    = 1'b1;
          state_next = ST_NEG;
        end else begin
          wd_inc = 1'b1;
`endif
        end
      end
      ST_LATCH: begin
        capture     = RWn;
        strobes_off = 1'b1;
        state_next  = ST_HOLD;
      end
      ST_NEG: begin
        strobes_off = 1'b1;
        state_next  = ST_HOLD;
      end
      ST_HOLD: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus-facing registers; ADDR/DBUS_OUT stay put through HOLD for slave hold time
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ASn      <= STROBE_IDLE;
      UDSn     <= STROBE_IDLE;
      LDSn     <= STROBE_IDLE;
      RWn      <= STROBE_IDLE;
      DBUS_OE  <= 1'b0;
      ADDR     <= '0;
      DBUS_OUT <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      uds_q    <= STROBE_IDLE;
      lds_q    <= STROBE_IDLE;
      err_q    <= 1'b0;
    end else begin
      ack <= illegal | finish;
      err <= illegal | (finish & err_q);
      if (accept) begin
        ADDR     <= req_addr;
        RWn      <= req_rwn;
        DBUS_OUT <= req_wdata;
        uds_q    <= req_uds_n;
        lds_q    <= req_lds_n;
        err_q    <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
      if (as_on) ASn <= 1'b0;
      if (ds_on) begin
        UDSn <= uds_q;
        LDSn <= lds_q;
      end
      if (strobes_off) begin
        ASn  <= STROBE_IDLE;
        UDSn <= STROBE_IDLE;
        LDSn <= STROBE_IDLE;
      end
      if (oe_on)   DBUS_OE <= 1'b1;
      if (capture) rdata   <= DBUS_IN;
      if (finish) begin
        RWn     <= STROBE_IDLE;
        DBUS_OE <= 1'b0;
      end
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt  <= '0;
      to_q    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
      if (accept)       to_q <= 1'b0;
      else if (wd_fire) to_q <= 1'b1;
      timeout <= finish & to_q;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_zorro2_bus_master.sv
// Self-checking bench for zorro2_bus_master: directed vector table, hang/reset
// sequences and random cycles scored against a timing-rule model (WATCHDOG_EN aware).
module tb_zorro2_bus_master;

  localparam int TB_SYNC    = 2;
  localparam int TB_TIMEOUT = 8;
  localparam int BIG        = 1000000;
  localparam int MAX_CYCLES = 200;

  logic        CLK, RESET;
  logic        req, req_rwn, req_uds_n, req_lds_n;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic        ack, err, timeout, busy;
  logic [15:0] rdata;
  logic [22:0] ADDR;
  logic [15:0] DBUS_OUT, DBUS_IN;
  logic        DBUS_OE, ASn, UDSn, LDSn, RWn, DTACKn, BERRn;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_rdata;

  typedef struct {
    logic        rwn;
    logic [22:0] addr;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] wdata;
    logic [15:0] bus_data;
    int          dtack_delay;
    int          berr_delay;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_as_low;
    int          exp_ack_idx;
    int          exp_oe_clks;
  } vector_t;

  typedef struct {
    int          ack_idx;
    int          as_low;
    int          oe_clks;
    int          uds_low;
    int          lds_low;
    int          uds_first;
    int          lds_first;
    logic        err;
    logic        timeout;
    logic [15:0] rdata;
  } prediction_t;

  zorro2_bus_master #(.SYNC_STAGES(TB_SYNC), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_rwn(req_rwn), .req_addr(req_addr),
    .req_uds_n(req_uds_n), .req_lds_n(req_lds_n), .req_wdata(req_wdata),
    .ack(ack), .err(err), .timeout(timeout), .rdata(rdata), .busy(busy),
    .ADDR(ADDR), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE), .DBUS_IN(DBUS_IN),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DTACKn(DTACKn), .BERRn(BERRn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edges counted from the accepting edge (0). ASn falls at edge 1; a response
  // driven k clocks later is visible after SYNC more edges; WAIT first looks at edge 3.
  function automatic prediction_t predict(input vector_t v, input logic [15:0] prev);
    prediction_t p;
    int d_edge, b_edge, decision, n, ds_low, ds_first;
    logic is_err, is_to;
    p.rdata   = prev;
    p.timeout = 1'b0;
    if (v.uds_n && v.lds_n) begin
      p.ack_idx = 0; p.as_low = 0; p.oe_clks = 0; p.uds_low = 0; p.lds_low = 0;
      p.uds_first = -1; p.lds_first = -1; p.err = 1'b1;
      return p;
    end
    d_edge = (v.dtack_delay < 0) ? BIG : ((2 + v.dtack_delay + TB_SYNC < 3) ? 3 : 2 + v.dtack_delay + TB_SYNC);
    b_edge = (v.berr_delay  < 0) ? BIG : ((2 + v.berr_delay  + TB_SYNC < 3) ? 3 : 2 + v.berr_delay  + TB_SYNC);
    is_err   = (b_edge <= d_edge);
    decision = is_err ? b_edge : d_edge;
    is_to    = 1'b0;
`ifdef WATCHDOG_EN
    if (decision > 2 + TB_TIMEOUT) begin
      decision = 2 + TB_TIMEOUT;
      is_err   = 1'b1;
      is_to    = 1'b1;
    end
`endif
    n        = decision + 1;
    ds_low   = v.rwn ? n - 1 : n - 2;
    ds_first = v.rwn ? 1 : 2;
    p.as_low    = n - 1;
    p.ack_idx   = n + 1;
    p.oe_clks   = v.rwn ? 0 : n;
    p.uds_low   = v.uds_n ? 0 : ds_low;
    p.lds_low   = v.lds_n ? 0 : ds_low;
    p.uds_first = v.uds_n ? -1 : ds_first;
    p.lds_first = v.lds_n ? -1 : ds_first;
    p.err       = is_err;
    p.timeout   = is_to;
    if (!is_err && v.rwn) p.rdata = v.bus_data;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request, plays the slave (DTACKn/BERRn k clocks after ASn falls), measures the cycle
  task automatic applyStimulus(input vector_t v, input prediction_t p, input string tag);
    int as_low, oe_clks, uds_low, lds_low, uds_first, lds_first, as_fall, ack_idx;
    logic busy0, ack_err, ack_to, ack_busy, ack_rwn;
    logic [15:0] ack_rdata;
    req_rwn = v.rwn; req_addr = v.addr; req_uds_n = v.uds_n; req_lds_n = v.lds_n;
    req_wdata = v.wdata; DBUS_IN = v.bus_data; req = 1'b1;
    @(posedge CLK); #1;
    req = 1'b0;
    as_low = 0; oe_clks = 0; uds_low = 0; lds_low = 0;
    uds_first = -1; lds_first = -1; as_fall = -1; ack_idx = -1;
    busy0 = 1'b0; ack_err = 1'b0; ack_to = 1'b0; ack_busy = 1'b1; ack_rwn = 1'b0; ack_rdata = '0;
    for (int e = 0; e < MAX_CYCLES; e++) begin
      if (e > 0) begin @(posedge CLK); #1; end
      if (e == 0) busy0 = busy;
      if (!ASn) begin
        if (as_fall < 0) begin
          as_fall = e;
          checkOutput({tag, ".addr"}, 32'(ADDR), 32'(v.addr));
          checkOutput({tag, ".rwn"}, 32'(RWn), 32'(v.rwn));
          checkOutput({tag, ".wdata"}, 32'(DBUS_OUT), 32'(v.wdata));
        end
        as_low++;
        if (v.dtack_delay >= 0 && e - as_fall == v.dtack_delay) DTACKn = 1'b0;
        if (v.berr_delay  >= 0 && e - as_fall == v.berr_delay)  BERRn  = 1'b0;
      end else begin
        DTACKn = 1'b1;
        BERRn  = 1'b1;
      end
      if (!UDSn) begin uds_low++; if (uds_first < 0) uds_first = e; end
      if (!LDSn) begin lds_low++; if (lds_first < 0) lds_first = e; end
      if (DBUS_OE) oe_clks++;
      if (ack) begin
        ack_idx = e; ack_err = err; ack_to = timeout; ack_busy = busy;
        ack_rwn = RWn; ack_rdata = rdata;
        break;
      end
    end
    DTACKn = 1'b1;
    BERRn  = 1'b1;
    checkOutput({tag, ".busy0"}, 32'(busy0), 32'(p.ack_idx != 0));
    checkOutput({tag, ".ackIdx"}, ack_idx, p.ack_idx);
    checkOutput({tag, ".err"}, 32'(ack_err), 32'(p.err));
    checkOutput({tag, ".timeout"}, 32'(ack_to), 32'(p.timeout));
    checkOutput({tag, ".busyAtAck"}, 32'(ack_busy), 32'd0);
    checkOutput({tag, ".rwnAtAck"}, 32'(ack_rwn), 32'd1);
    checkOutput({tag, ".rdata"}, 32'(ack_rdata), 32'(p.rdata));
    checkOutput({tag, ".asLow"}, as_low, p.as_low);
    checkOutput({tag, ".oeClks"}, oe_clks, p.oe_clks);
    checkOutput({tag, ".udsLow"}, uds_low, p.uds_low);
    checkOutput({tag, ".ldsLow"}, lds_low, p.lds_low);
    checkOutput({tag, ".udsFirst"}, uds_first, p.uds_first);
    checkOutput({tag, ".ldsFirst"}, lds_first, p.lds_first);
    model_rdata = p.rdata;
  endtask

  initial begin
    vector_t     vectors[7];
    vector_t     v;
    prediction_t p;
    int          busy_low, acks;

    //             rwn   addr          uds   lds   wdata     bus       dk  bk  err   rdata     asL ack oe
    vectors[0] = '{1'b1, 23'h10_0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF,  0, -1, 1'b0, 16'hBEEF, 4,  6,  0};
    vectors[1] = '{1'b0, 23'h74_0024, 1'b0, 1'b1, 16'h1234, 16'h0000,  4, -1, 1'b0, 16'hBEEF, 8,  10, 9};
    vectors[2] = '{1'b1, 23'h00_0400, 1'b0, 1'b0, 16'h0000, 16'h5555,  0,  0, 1'b1, 16'hBEEF, 4,  6,  0};
    vectors[3] = '{1'b1, 23'h00_0010, 1'b1, 1'b1, 16'h0000, 16'h7777,  0, -1, 1'b1, 16'hBEEF, 0,  0,  0};
    vectors[4] = '{1'b1, 23'h20_0102, 1'b1, 1'b0, 16'h0000, 16'h0A5A,  1, -1, 1'b0, 16'h0A5A, 5,  7,  0};
    vectors[5] = '{1'b0, 23'h3F_FFFF, 1'b0, 1'b0, 16'hCAFE, 16'h0000, -1,  2, 1'b1, 16'h0A5A, 6,  8,  7};
    vectors[6] = '{1'b1, 23'h55_AAAA, 1'b0, 1'b0, 16'h0000, 16'h8001,  3,  5, 1'b0, 16'h8001, 7,  9,  0};

    RESET = 1'b1; req = 1'b0; req_rwn = 1'b1; req_addr = '0; req_uds_n = 1'b1; req_lds_n = 1'b1;
    req_wdata = '0; DBUS_IN = '0; DTACKn = 1'b1; BERRn = 1'b1;
    #2;
    checkOutput("reset.strobes", 32'({ASn, UDSn, LDSn, RWn}), 32'hF);
    checkOutput("reset.oe", 32'(DBUS_OE), 32'd0);
    checkOutput("reset.addr", 32'(ADDR), 32'd0);
    checkOutput("reset.dbusOut", 32'(DBUS_OUT), 32'd0);
    checkOutput("reset.rdata", 32'(rdata), 32'd0);
    checkOutput("reset.flags", 32'({ack, err, timeout, busy}), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_rdata = '0;

    for (int i = 0; i < 7; i++) begin
      p = predict(vectors[i], model_rdata);
      p.err     = vectors[i].exp_err;
      p.rdata   = vectors[i].exp_rdata;
      p.as_low  = vectors[i].exp_as_low;
      p.ack_idx = vectors[i].exp_ack_idx;
      p.oe_clks = vectors[i].exp_oe_clks;
      applyStimulus(vectors[i], p, $sformatf("vec%0d", i));
    end

    v = '{1'b1, 23'h00_0123, 1'b0, 1'b0, 16'h0000, 16'hDEAD, -1, -1, 1'b0, 16'h0, 0, 0, 0};
`ifdef WATCHDOG_EN
    applyStimulus(v, predict(v, model_rdata), "watchdog");
`endif

    // Unanswered read, then asynchronous reset while the FSM sits in WAIT
    req_rwn = v.rwn; req_addr = v.addr; req_uds_n = v.uds_n; req_lds_n = v.lds_n;
    DBUS_IN = v.bus_data; req = 1'b1;
    @(posedge CLK); #1;
    req = 1'b0;
`ifdef WATCHDOG_EN
    repeat (4) begin @(posedge CLK); #1; end
`else
    busy_low = 0;
    acks     = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (!busy) busy_low++;
      if (ack) acks++;
    end
    checkOutput("hang.busyLow", busy_low, 0);
    checkOutput("hang.acks", acks, 0);
`endif
    #3;
    RESET = 1'b1;
    #1;
    checkOutput("midReset.strobes", 32'({ASn, UDSn, LDSn}), 32'h7);
    checkOutput("midReset.oe", 32'(DBUS_OE), 32'd0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_rdata = '0;
    checkOutput("midReset.rdata", 32'(rdata), 32'd0);
    v = '{1'b1, 23'h10_0000, 1'b0, 1'b0, 16'h0000, 16'h4321, 0, -1, 1'b0, 16'h0, 0, 0, 0};
    applyStimulus(v, predict(v, model_rdata), "recover");

    for (int i = 0; i < 24; i++) begin
      v.rwn         = 1'($urandom_range(0, 1));
      v.addr        = 23'($urandom);
      v.uds_n       = 1'($urandom_range(0, 1));
      v.lds_n       = 1'($urandom_range(0, 1));
      v.wdata       = 16'($urandom);
      v.bus_data    = 16'($urandom);
      v.dtack_delay = int'($urandom_range(0, 6));
      v.berr_delay  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      applyStimulus(v, predict(v, model_rdata), $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
